// File: rtl/riscv_pkg.sv
// Shared RV32I immediate-format types used by the encoder, the scatter logic and the extender.
package riscv_pkg;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } immsrc_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_RANGE = 2'b01,
    ERR_ALIGN = 2'b10,
    ERR_SRC   = 2'b11
  } imm_err_e;

  // True when v[31:lsb] are all equal, i.e. v is a sign-extension of its low lsb+1 bits.
  function automatic logic fits_signed(input logic [31:0] v, input int unsigned lsb);
    logic signed [31:0] s;
    s = $signed(v) >>> lsb;
    return (s == '0) || (s == '1);
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Datapath immediate extender: rebuilds the 32-bit immediate from instruction bits [31:7].
module imm_extend
  import riscv_pkg::*;
(
  input  logic [31:7] instr,
  input  immsrc_e     src,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (src)
      IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/imm_scatter.sv
// Combinational scatter of an immediate into RV32I bit positions, with the clear-mask and error code.
module imm_scatter
  import riscv_pkg::*;
(
  input  logic [2:0]  immsrc,
  input  logic [31:0] imm,
  output logic [31:0] bits,
  output logic [31:0] mask,
  output imm_err_e    err
);

  immsrc_e     src;
  logic [31:0] raw;

  assign src = immsrc_e'(immsrc);

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    raw  = '0;
    mask = '0;
    err  = ERR_NONE;
    case (src)
      IMM_I: begin
        raw  = {imm[11:0], 20'b0};
        mask = 32'hFFF0_0000;
        if (!fits_signed(imm, 11)) err = ERR_RANGE;
      end
      IMM_S: begin
        raw  = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        mask = 32'hFE00_0F80;
        if (!fits_signed(imm, 11)) err = ERR_RANGE;
      end
      IMM_B: begin
        raw  = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        mask = 32'hFE00_0F80;
        if (imm[0])                     err = ERR_ALIGN;
        else if (!fits_signed(imm, 12)) err = ERR_RANGE;
      end
      IMM_J: begin
        raw  = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        mask = 32'hFFFF_F000;
        if (imm[0])                     err = ERR_ALIGN;
        else if (!fits_signed(imm, 20)) err = ERR_RANGE;
      end
      IMM_U: begin
        raw  = {imm[31:12], 12'b0};
        mask = 32'hFFFF_F000;
        if (imm[11:0] != 12'b0) err = ERR_ALIGN;
      end
      default: err = ERR_SRC;  // mask stays zero: the base word passes through untouched
    endcase
    bits = (err == ERR_NONE) ? raw : '0;
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder tagging each word with its imem byte address.
// Optional IMM_ROUNDTRIP_CHECK_EN adds an extender round-trip check and the rt_mismatch output.
module imm_encoder
  import riscv_pkg::*;
#(
  parameter int unsigned            ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]      ADDR_BASE = '0,
  parameter int unsigned            ERRCNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_immsrc,
  input  logic [31:0]         in_base,
  input  logic [31:0]         in_imm,
  input  logic                in_restart,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [1:0]          out_err,
`ifdef IMM_ROUNDTRIP_CHECK_EN
  output logic                rt_mismatch,
`endif
  output logic [ERRCNT_W-1:0] err_count
);

  logic              s1_v, s1_rdy, s2_rdy, accept, s1_go;
  logic [2:0]        s1_src;
  logic [31:0]       s1_base, s1_imm;
  logic [ADDR_W-1:0] s1_addr, addr_cnt, tag;
  logic [31:0]       sc_bits, sc_mask;
  imm_err_e          sc_err;

  assign s2_rdy   = !out_valid || out_ready;
  assign s1_rdy   = !s1_v || s2_rdy;
  assign in_ready = s1_rdy;
  assign accept   = in_valid && s1_rdy;
  assign s1_go    = s1_v && s2_rdy;
  assign tag      = in_restart ? ADDR_BASE : addr_cnt;

  // Stage 1: capture the request and assign its address tag.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      s1_v     <= 1'b0;
      s1_src   <= '0;
      s1_base  <= '0;
      s1_imm   <= '0;
      s1_addr  <= '0;
      addr_cnt <= ADDR_BASE;
    end else begin
      if (s1_rdy) s1_v <= in_valid;
      if (accept) begin
        s1_src   <= in_immsrc;
        s1_base  <= in_base;
        s1_imm   <= in_imm;
        s1_addr  <= tag;
        addr_cnt <= tag + ADDR_W'(4);
      end else if (in_restart) begin
        addr_cnt <= ADDR_BASE;
      end
    end
  end

  imm_scatter u_scatter (
    .immsrc (s1_src),
    .imm    (s1_imm),
    .bits   (sc_bits),
    .mask   (sc_mask),
    .err    (sc_err)
  );

  // Stage 2: registered encoded word, plus the saturating error counter on output handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      out_err   <= ERR_NONE;
      err_count <= '0;
    end else begin
      if (s2_rdy) out_valid <= s1_v;
      if (s1_go) begin
        out_instr <= (s1_base & ~sc_mask) | sc_bits;
        out_addr  <= s1_addr;
        out_err   <= sc_err;
      end
      if (out_valid && out_ready && (out_err != ERR_NONE) && (err_count != '1))
        err_count <= err_count + ERRCNT_W'(1);
    end
  end

`ifdef IMM_ROUNDTRIP_CHECK_EN
  logic [31:0] s2_imm, ext_imm;
  immsrc_e     s2_src;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_imm <= '0;
      s2_src <= IMM_I;
    end else if (s1_go) begin
      s2_imm <= s1_imm;
      s2_src <= immsrc_e'(s1_src);
    end
  end

  imm_extend u_extend (
    .instr (out_instr[31:7]),
    .src   (s2_src),
    .imm   (ext_imm)
  );

  assign rt_mismatch = out_valid && (out_err == ERR_NONE) && (ext_imm != s2_imm);

  rt_never_mismatch: assert property (@(posedge clk) disable iff (!rst_n) !rt_mismatch);
`endif

endmodule
